alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//   Decode-and-issue stage that drives the ALU operand/op-select interface (a = rs1/pc/0, b = rs2/imm, alu_select_e op).
//   Accepts raw RV32I instructions over valid/ready, reads the register file and decodes OP/OP-IMM/LUI/AUIPC.
//   Delivers a registered ALU request plus writeback tag to execute over valid/ready.
//   Two-entry elastic buffer (output reg + skid reg): full throughput, no combinational ready path from execute to fetch.
// PARAMETERS
//   XLEN            32  datapath width
//   REG_ADDR_WIDTH  5   register index width; shift amount = b[REG_ADDR_WIDTH-1:0]
// PORTS
//   clk_i          in   1               clock, rising edge
//   rst_i          in   1               synchronous reset, active-high
//   flush_i        in   1               discard all buffered requests
//   instr_i        in   32              instruction word
//   pc_i           in   XLEN            PC of instr_i (AUIPC)
//   instr_valid_i  in   1               instr_i/pc_i valid
//   instr_ready_o  out  1               stage can accept this cycle
//   rs1_addr_o     out  REG_ADDR_WIDTH  regfile read addr = instr_i[19:15], combinational
//   rs2_addr_o     out  REG_ADDR_WIDTH  regfile read addr = instr_i[24:20], combinational
//   rs1_data_i     in   XLEN            regfile data, same-cycle async read
//   rs2_data_i     in   XLEN            regfile data, same-cycle async read
//   alu_port_a_o   out  XLEN            ALU operand a
//   alu_port_b_o   out  XLEN            ALU operand b
//   alu_op_sel_o   out  alu_select_e    ALU operation
//   rd_addr_o      out  REG_ADDR_WIDTH  destination register
//   rd_we_o        out  1               writeback enable
//   illegal_o      out  1               request carries an unsupported instruction
//   issue_valid_o  out  1               request valid
//   issue_ready_i  in   1               execute accepts
// BEHAVIOUR
// - Decode, opcode instr[6:0]:
//     0110011 OP:     a=rs1, b=rs2
//     0010011 OP-IMM: a=rs1, b=sext(instr[31:20]); shifts b=zext(instr[24:20])
//     0110111 LUI:    a=0,   b={instr[31:12],12'b0}, op OP_ADD
//     0010111 AUIPC:  a=pc_i, b={instr[31:12],12'b0}, op OP_ADD
// - funct3: 000 ADD (OP with funct7=0100000 -> SUB); 100 XOR; 110 OR; 111 AND;
//   001 SLL (funct7 must be 0000000); 101 SRL (0000000) / SRA (0100000).
// - funct7 check applies to OP-IMM shifts via instr[31:25]; OP non-shift ops require funct7 0000000 (0100000 for SUB only).
// - Unsupported (other opcodes, funct3 010/011, bad funct7): op=OP_UNKNOWN, a=b=0, rd_we_o=0, illegal_o=1.
//   Still issued as a normal request, never dropped.
// - rd_addr_o=instr[11:7]; rd_we_o=0 when rd==0.
// - Handshake: accept = instr_valid_i & instr_ready_o; issue = issue_valid_o & issue_ready_i.
//   Payload held stable while issue_valid_o & !issue_ready_i.
// - instr_ready_o = !skid_valid_q & !rst_i (registered state, no path from issue_ready_i).
// - FSM:
//     EMPTY: accept -> ONE
//     ONE:   accept & !issue -> TWO (new req into skid); accept & issue -> ONE (new req into out reg);
//            !accept & issue -> EMPTY
//     TWO:   issue -> ONE (skid moves to out reg); no accept possible
// - Latency: accepted at edge N -> issue_valid_o=1 after edge N. Order strictly preserved.
// - flush_i (sync): next state EMPTY; overrides same-cycle accept and issue; the instruction offered that cycle is dropped.
// - Reset (sync, mid-operation too): state EMPTY, issue_valid_o=0, alu_op_sel_o=OP_UNKNOWN, illegal_o=0, rd_we_o=0,
//   all data/address outputs 0; instr_ready_o=0 while rst_i, 1 the cycle after.
// TESTING
// - add x3,x1,x2 with x1=5, x2=7, issue_ready_i=1 -> next cycle a=5, b=7, OP_ADD, rd=3, rd_we=1, 1 req/cycle streaming.
// - srai x4,x1,3 with x1=0x8000_0000 -> OP_SRA, b=3; slli funct7=0100000 -> OP_UNKNOWN, illegal_o=1, rd_we_o=0.
// - lui x5,0xABCDE -> a=0, b=0xABCDE000; auipc at pc=0x100, imm 1 -> a=0x100, b=0x1000, OP_ADD.
// - Hold issue_ready_i=0, offer 3 instrs back-to-back -> 2 accepted, instr_ready_o=0 on the 3rd;
//   release -> issued in order with payload stable during the stall.
// - Buffer in TWO, assert flush_i with instr_valid_i=1 -> next cycle issue_valid_o=0, instr_ready_o=1, flushed instr never issued.
// - Assert rst_i while in TWO -> next cycle issue_valid_o=0, alu_op_sel_o=OP_UNKNOWN; rd x0 write -> rd_we_o=0.

Source files
------------

// File: rtl/alu_issue_stage.sv
//------------------------------------------------------------------------------
// Module  : alu_issue_stage
// Brief   : RV32I OP/OP-IMM/LUI/AUIPC decode with a two-entry elastic issue
//           buffer that feeds the ALU request port of execute.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package alu_issue_pkg;
   typedef enum logic [3:0] {
      OP_ADD     = 4'd0,
      OP_SUB     = 4'd1,
      OP_XOR     = 4'd2,
      OP_OR      = 4'd3,
      OP_AND     = 4'd4,
      OP_SLL     = 4'd5,
      OP_SRL     = 4'd6,
      OP_SRA     = 4'd7,
      OP_UNKNOWN = 4'd15
   } alu_select_e;
endpackage

module alu_issue_stage
   import alu_issue_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      flush_i,
   input  logic [31:0]               instr_i,
   input  logic [XLEN-1:0]           pc_i,
   input  logic                      instr_valid_i,
   output logic                      instr_ready_o,
   output logic [REG_ADDR_WIDTH-1:0] rs1_addr_o,
   output logic [REG_ADDR_WIDTH-1:0] rs2_addr_o,
   input  logic [XLEN-1:0]           rs1_data_i,
   input  logic [XLEN-1:0]           rs2_data_i,
   output logic [XLEN-1:0]           alu_port_a_o,
   output logic [XLEN-1:0]           alu_port_b_o,
   output alu_select_e               alu_op_sel_o,
   output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
   output logic                      rd_we_o,
   output logic                      illegal_o,
   output logic                      issue_valid_o,
   input  logic                      issue_ready_i
);

   typedef struct packed {
      logic [XLEN-1:0]           a;
      logic [XLEN-1:0]           b;
      alu_select_e               op;
      logic [REG_ADDR_WIDTH-1:0] rd;
      logic                      we;
      logic                      illegal;
   } req_t;

   localparam req_t c_req_reset = '{a: '0, b: '0, op: OP_UNKNOWN, rd: '0, we: 1'b0, illegal: 1'b0};

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_e;

   state_e      r_state;
   state_e      w_state_nxt;
   req_t        r_out;
   req_t        r_skid;
   req_t        w_dec;
   alu_select_e w_op;
   logic [6:0]  w_opcode;
   logic [2:0]  w_f3;
   logic        w_f7_zero;
   logic        w_f7_alt;
   logic        w_accept;
   logic        w_issue;
   logic        w_load_new;
   logic        w_load_skid;
   logic        w_skid_to_out;

   assign w_opcode  = instr_i[6:0];
   assign w_f3      = instr_i[14:12];
   assign w_f7_zero = (instr_i[31:25] == 7'b0000000);
   assign w_f7_alt  = (instr_i[31:25] == 7'b0100000);

   assign rs1_addr_o = instr_i[15 +: REG_ADDR_WIDTH];
   assign rs2_addr_o = instr_i[20 +: REG_ADDR_WIDTH];

   // Decode of the instruction currently offered by fetch.
   always_comb begin
      w_op    = OP_UNKNOWN;
      w_dec.a = '0;
      w_dec.b = '0;
      case (w_opcode)
         7'b0110011, 7'b0010011: begin
            w_dec.a = rs1_data_i;
            if (w_opcode == 7'b0110011) begin
               w_dec.b = rs2_data_i;
            end else if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
               w_dec.b = XLEN'(instr_i[24:20]);
            end else begin
               w_dec.b = XLEN'($signed(instr_i[31:20]));
            end
            // Register-register ops check funct7 everywhere; OP-IMM only for shifts.
            case (w_f3)
               3'b000: w_op = (w_opcode == 7'b0010011 || w_f7_zero) ? OP_ADD :
                              w_f7_alt ? OP_SUB : OP_UNKNOWN;
               3'b001: w_op = w_f7_zero ? OP_SLL : OP_UNKNOWN;
               3'b100: w_op = (w_opcode == 7'b0010011 || w_f7_zero) ? OP_XOR : OP_UNKNOWN;
               3'b101: w_op = w_f7_zero ? OP_SRL : w_f7_alt ? OP_SRA : OP_UNKNOWN;
               3'b110: w_op = (w_opcode == 7'b0010011 || w_f7_zero) ? OP_OR : OP_UNKNOWN;
               3'b111: w_op = (w_opcode == 7'b0010011 || w_f7_zero) ? OP_AND : OP_UNKNOWN;
               default: w_op = OP_UNKNOWN;
            endcase
         end
         7'b0110111, 7'b0010111: begin
            w_op    = OP_ADD;
            w_dec.a = (w_opcode == 7'b0010111) ? pc_i : '0;
            w_dec.b = XLEN'($signed({instr_i[31:12], 12'b0}));
         end
         default: w_op = OP_UNKNOWN;
      endcase
      w_dec.op      = w_op;
      w_dec.illegal = (w_op == OP_UNKNOWN);
      w_dec.rd      = instr_i[7 +: REG_ADDR_WIDTH];
      w_dec.we      = !w_dec.illegal && (w_dec.rd != '0);
      if (w_dec.illegal) begin
         w_dec.a = '0;
         w_dec.b = '0;
      end
   end

   assign instr_ready_o = (r_state != S_TWO) && !rst_i;
   assign issue_valid_o = (r_state != S_EMPTY);
   assign w_accept      = instr_valid_i && instr_ready_o;
   assign w_issue       = issue_valid_o && issue_ready_i;

   always_comb begin
      w_state_nxt   = r_state;
      w_load_new    = 1'b0;
      w_load_skid   = 1'b0;
      w_skid_to_out = 1'b0;
      case (r_state)
         S_EMPTY: begin
            if (w_accept) begin
               w_state_nxt = S_ONE;
               w_load_new  = 1'b1;
            end
         end
         S_ONE: begin
            if (w_accept && !w_issue) begin
               w_state_nxt = S_TWO;
               w_load_skid = 1'b1;
            end else if (w_accept && w_issue) begin
               w_load_new  = 1'b1;
            end else if (w_issue) begin
               w_state_nxt = S_EMPTY;
            end
         end
         S_TWO: begin
            if (w_issue) begin
               w_state_nxt   = S_ONE;
               w_skid_to_out = 1'b1;
            end
         end
         default: w_state_nxt = S_EMPTY;
      endcase
      if (flush_i) begin
         w_state_nxt   = S_EMPTY;
         w_load_new    = 1'b0;
         w_load_skid   = 1'b0;
         w_skid_to_out = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_EMPTY;
         r_out   <= c_req_reset;
         r_skid  <= c_req_reset;
      end else begin
         r_state <= w_state_nxt;
         if (w_load_new) begin
            r_out <= w_dec;
         end else if (w_skid_to_out) begin
            r_out <= r_skid;
         end
         if (w_load_skid) begin
            r_skid <= w_dec;
         end
      end
   end

   assign alu_port_a_o = r_out.a;
   assign alu_port_b_o = r_out.b;
   assign alu_op_sel_o = r_out.op;
   assign rd_addr_o    = r_out.rd;
   assign rd_we_o      = r_out.we;
   assign illegal_o    = r_out.illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
//------------------------------------------------------------------------------
// Module  : tb_alu_issue_stage
// Brief   : Directed bench for alu_issue_stage with a queue-based request model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_issue_stage;
   import alu_issue_pkg::*;

   logic        clk = 1'b0;
   logic        rst, flush, instr_valid, instr_ready, issue_valid, issue_ready;
   logic [31:0] instr, pc, rs1_data, rs2_data, port_a, port_b;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr;
   logic        rd_we, illegal;
   alu_select_e op_sel;
   logic [31:0] rf [32];

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      alu_select_e op;
      logic [4:0]  rd;
      logic        we;
      logic        ill;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   bit   m_acc, m_iss;

   always #5 clk = ~clk;

   assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : rf[rs1_addr];
   assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : rf[rs2_addr];

   alu_issue_stage #(.XLEN(32), .REG_ADDR_WIDTH(5)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .instr_i(instr), .pc_i(pc),
      .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
      .rs1_addr_o(rs1_addr), .rs2_addr_o(rs2_addr),
      .rs1_data_i(rs1_data), .rs2_data_i(rs2_data),
      .alu_port_a_o(port_a), .alu_port_b_o(port_b), .alu_op_sel_o(op_sel),
      .rd_addr_o(rd_addr), .rd_we_o(rd_we), .illegal_o(illegal),
      .issue_valid_o(issue_valid), .issue_ready_i(issue_ready)
   );

   function automatic exp_t ref_dec(logic [31:0] ins, logic [31:0] p);
      exp_t        e;
      alu_select_e tab [8];
      logic [6:0]  f7;
      logic [2:0]  f3;
      logic [31:0] v1, v2;
      tab = '{OP_ADD, OP_SLL, OP_UNKNOWN, OP_UNKNOWN, OP_XOR, OP_SRL, OP_OR, OP_AND};
      f7 = ins[31:25];
      f3 = ins[14:12];
      v1 = (ins[19:15] == 5'd0) ? 32'd0 : rf[ins[19:15]];
      v2 = (ins[24:20] == 5'd0) ? 32'd0 : rf[ins[24:20]];
      e.op = OP_UNKNOWN;
      e.a  = 32'd0;
      e.b  = 32'd0;
      if (ins[6:0] == 7'h33) begin
         e.a = v1;
         e.b = v2;
         if (f7 == 7'h00) e.op = tab[f3];
         else if (f7 == 7'h20 && f3 == 3'd0) e.op = OP_SUB;
         else if (f7 == 7'h20 && f3 == 3'd5) e.op = OP_SRA;
      end else if (ins[6:0] == 7'h13) begin
         e.a = v1;
         if (f3 == 3'd1 || f3 == 3'd5) begin
            e.b = {27'd0, ins[24:20]};
            if (f7 == 7'h00) e.op = tab[f3];
            else if (f7 == 7'h20 && f3 == 3'd5) e.op = OP_SRA;
         end else begin
            e.b  = {{20{ins[31]}}, ins[31:20]};
            e.op = tab[f3];
         end
      end else if (ins[6:0] == 7'h37) begin
         e.b  = {ins[31:12], 12'h000};
         e.op = OP_ADD;
      end else if (ins[6:0] == 7'h17) begin
         e.a  = p;
         e.b  = {ins[31:12], 12'h000};
         e.op = OP_ADD;
      end
      e.ill = (e.op == OP_UNKNOWN);
      if (e.ill) begin
         e.a = 32'd0;
         e.b = 32'd0;
      end
      e.rd = ins[11:7];
      e.we = !e.ill && (e.rd != 5'd0);
      return e;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: the buffer is just an ordered queue of at most two requests.
   always @(posedge clk) begin
      m_acc = instr_valid && (q.size() < 2) && !rst;
      m_iss = (q.size() > 0) && issue_ready;
      if (rst || flush) begin
         q.delete();
      end else begin
         if (m_iss) q.delete(0);
         if (m_acc) q.push_back(ref_dec(instr, pc));
      end
   end

   always @(negedge clk) begin
      chk("instr_ready", 32'(instr_ready), 32'((q.size() < 2) && !rst));
      chk("issue_valid", 32'(issue_valid), 32'(q.size() != 0));
      chk("rs1_addr", 32'(rs1_addr), 32'(instr[19:15]));
      chk("rs2_addr", 32'(rs2_addr), 32'(instr[24:20]));
      if (q.size() != 0) begin
         chk("port_a", port_a, q[0].a);
         chk("port_b", port_b, q[0].b);
         chk("op_sel", 32'(op_sel), 32'(q[0].op));
         chk("rd_addr", 32'(rd_addr), 32'(q[0].rd));
         chk("rd_we", 32'(rd_we), 32'(q[0].we));
         chk("illegal", 32'(illegal), 32'(q[0].ill));
      end
   end

   function automatic logic [31:0] r_ins(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                         logic [2:0] f3, logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction

   function automatic logic [31:0] i_ins(logic [11:0] imm, logic [4:0] rs1,
                                         logic [2:0] f3, logic [4:0] rd);
      return {imm, rs1, f3, rd, 7'h13};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(logic [31:0] ins, logic [31:0] p);
      instr       = ins;
      pc          = p;
      instr_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         logic rdy;
         rdy = instr_ready;
         cyc();
         if (rdy) begin
            instr_valid = 1'b0;
            return;
         end
      end
      n_cmp++;
      n_err++;
      $display("FAIL offer_timeout: got not-accepted expected accepted for %h", ins);
      instr_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; flush = 1'b0; instr = 32'd0; pc = 32'd0;
      instr_valid = 1'b0; issue_ready = 1'b1;
      for (int i = 0; i < 32; i++) rf[i] = 32'h1111_0000 + i;
      rf[1] = 32'd5;
      rf[2] = 32'd7;
      repeat (3) cyc();
      chk("rst_ready", 32'(instr_ready), 32'd0);
      chk("rst_valid", 32'(issue_valid), 32'd0);
      chk("rst_op", 32'(op_sel), 32'(OP_UNKNOWN));
      chk("rst_a", port_a, 32'd0);
      chk("rst_we_ill", 32'({rd_we, illegal, rd_addr}), 32'd0);
      rst = 1'b0;
      cyc();
      chk("post_rst_ready", 32'(instr_ready), 32'd1);

      // Streaming with execute always ready.
      offer(r_ins(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'h0);
      chk("add_a", port_a, 32'd5);
      chk("add_b", port_b, 32'd7);
      chk("add_op", 32'(op_sel), 32'(OP_ADD));
      chk("add_rd", 32'({rd_we, rd_addr}), 32'h23);
      offer(r_ins(7'h20, 5'd1, 5'd2, 3'd0, 5'd7), 32'h0);
      chk("sub_op", 32'(op_sel), 32'(OP_SUB));
      offer(r_ins(7'h00, 5'd2, 5'd1, 3'd4, 5'd8), 32'h0);
      offer(r_ins(7'h00, 5'd2, 5'd1, 3'd6, 5'd8), 32'h0);
      offer(r_ins(7'h00, 5'd2, 5'd1, 3'd7, 5'd8), 32'h0);
      offer(r_ins(7'h00, 5'd2, 5'd1, 3'd1, 5'd8), 32'h0);
      offer(r_ins(7'h00, 5'd2, 5'd1, 3'd5, 5'd8), 32'h0);
      offer(r_ins(7'h20, 5'd2, 5'd1, 3'd5, 5'd8), 32'h0);
      offer(r_ins(7'h01, 5'd2, 5'd1, 3'd0, 5'd8), 32'h0);
      chk("badf7_ill", 32'({illegal, rd_we}), 32'h2);
      offer(r_ins(7'h00, 5'd2, 5'd1, 3'd2, 5'd8), 32'h0);
      offer(i_ins(12'hFFF, 5'd1, 3'd0, 5'd9), 32'h0);
      chk("addi_neg_b", port_b, 32'hFFFF_FFFF);
      offer(i_ins(12'h0F0, 5'd2, 3'd4, 5'd9), 32'h0);
      offer(i_ins(12'h8F0, 5'd2, 3'd6, 5'd9), 32'h0);
      offer(i_ins(12'h00F, 5'd2, 3'd7, 5'd9), 32'h0);
      offer(i_ins(12'h005, 5'd2, 3'd3, 5'd9), 32'h0);
      offer({12'h0, 5'd1, 3'd2, 5'd9, 7'h03}, 32'h0);
      chk("load_ill", 32'(op_sel), 32'(OP_UNKNOWN));
      offer(r_ins(7'h00, 5'd2, 5'd1, 3'd0, 5'd0), 32'h0);
      chk("x0_we", 32'(rd_we), 32'd0);

      rf[1] = 32'h8000_0000;
      offer(i_ins(12'h403, 5'd1, 3'd5, 5'd4), 32'h0);
      chk("srai_op", 32'(op_sel), 32'(OP_SRA));
      chk("srai_b", port_b, 32'd3);
      chk("srai_a", port_a, 32'h8000_0000);
      offer(i_ins(12'h403, 5'd1, 3'd1, 5'd4), 32'h0);
      chk("slli_bad", 32'({illegal, rd_we, op_sel}), 32'h2F);
      chk("slli_bad_ab", port_a | port_b, 32'd0);
      offer({20'hABCDE, 5'd5, 7'h37}, 32'h0);
      chk("lui_a", port_a, 32'd0);
      chk("lui_b", port_b, 32'hABCD_E000);
      offer({20'h00001, 5'd6, 7'h17}, 32'h100);
      chk("auipc_a", port_a, 32'h100);
      chk("auipc_b", port_b, 32'h1000);
      cyc();

      // Back-pressure: two fill the buffer, the third waits.
      issue_ready = 1'b0;
      offer(i_ins(12'd1, 5'd0, 3'd0, 5'd10), 32'h0);
      offer(i_ins(12'd2, 5'd0, 3'd0, 5'd11), 32'h0);
      instr = i_ins(12'd3, 5'd0, 3'd0, 5'd12);
      instr_valid = 1'b1;
      chk("full_ready", 32'(instr_ready), 32'd0);
      cyc();
      cyc();
      chk("stall_b", port_b, 32'd1);
      issue_ready = 1'b1;
      offer(i_ins(12'd3, 5'd0, 3'd0, 5'd12), 32'h0);
      chk("stall_third", 32'({rd_addr, port_b[7:0]}), 32'h0C03);
      repeat (2) cyc();

      // Flush while full, with a new instruction offered.
      issue_ready = 1'b0;
      offer(i_ins(12'd1, 5'd0, 3'd0, 5'd10), 32'h0);
      offer(i_ins(12'd2, 5'd0, 3'd0, 5'd11), 32'h0);
      instr = i_ins(12'd4, 5'd0, 3'd0, 5'd13);
      instr_valid = 1'b1;
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      instr_valid = 1'b0;
      chk("flush_valid", 32'(issue_valid), 32'd0);
      chk("flush_ready", 32'(instr_ready), 32'd1);
      issue_ready = 1'b1;
      repeat (3) cyc();

      // Reset while full.
      issue_ready = 1'b0;
      offer(i_ins(12'd1, 5'd0, 3'd0, 5'd10), 32'h0);
      offer(i_ins(12'd2, 5'd0, 3'd0, 5'd11), 32'h0);
      rst = 1'b1;
      cyc();
      chk("midrst_valid", 32'(issue_valid), 32'd0);
      chk("midrst_op", 32'(op_sel), 32'(OP_UNKNOWN));
      rst = 1'b0;
      issue_ready = 1'b1;
      cyc();
      chk("midrst_ready", 32'(instr_ready), 32'd1);
      repeat (2) cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
